// File: rtl/serial_lane_sync.sv
// serial_lane_sync
//   Receive-side comma aligner for one serial lane. Shifts in an MSB-first
//   bit stream and searches it for the comma symbol in either running-disparity
//   form. A run of COMMA_COUNT commas on one 10-bit phase confirms lock. Once
//   locked, every aligned symbol is presented as a parallel word. LOSS_LIMIT
//   consecutive off-phase commas drop the lock.
//
// Ports
//   clk         bit-rate clock, all logic on the rising edge
//   reset       synchronous, active-high
//   serial_in   serial lane data, MSB of each symbol first
//   data_out    last aligned symbol (holds between strobes)
//   word_valid  one-cycle strobe, data_out updated this cycle
//   comma_det   data_out is a comma (qualified by word_valid)
//   active      lane locked
//   lock_lost   one-cycle strobe on loss of lock
//   state       00 SEARCH, 01 ALIGN, 10 ACTIVE
module serial_lane_sync #(
    parameter int unsigned          DATA_SIZE   = 10,
    parameter logic [DATA_SIZE-1:0] COMMA_P     = 10'h17C,
    parameter logic [DATA_SIZE-1:0] COMMA_N     = 10'h283,
    parameter int unsigned          COMMA_COUNT = 3,
    parameter int unsigned          LOSS_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 word_valid,
    output logic                 comma_det,
    output logic                 active,
    output logic                 lock_lost,
    output logic [1:0]           state
);

    localparam int unsigned CntW = $clog2(DATA_SIZE);

    typedef enum logic [1:0] {
        StSearch = 2'b00,
        StAlign  = 2'b01,
        StActive = 2'b10
    } state_e;

    state_e               state_q;
    logic [DATA_SIZE-1:0] shift_q;
    logic [CntW-1:0]      bit_cnt_q;
    logic [2:0]           align_cnt_q;
    logic [2:0]           misalign_cnt_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 word_valid_q;
    logic                 comma_det_q;
    logic                 active_q;
    logic                 lock_lost_q;

    logic [DATA_SIZE-1:0] cand;
    logic                 match;
    logic                 boundary;
    logic [2:0]           align_inc;
    logic [2:0]           misalign_inc;

    // The window includes the bit being sampled this cycle, so a comma is
    // recognised in the same cycle its last bit arrives.
    always_comb begin
        cand         = {shift_q[DATA_SIZE-2:0], serial_in};
        match        = (cand == COMMA_P) || (cand == COMMA_N);
        boundary     = (bit_cnt_q == CntW'(DATA_SIZE - 1));
        align_inc    = align_cnt_q + 3'd1;
        misalign_inc = misalign_cnt_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StSearch;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            align_cnt_q    <= '0;
            misalign_cnt_q <= '0;
            data_q         <= '0;
            word_valid_q   <= 1'b0;
            comma_det_q    <= 1'b0;
            active_q       <= 1'b0;
            lock_lost_q    <= 1'b0;
        end else begin
            shift_q      <= cand;
            bit_cnt_q    <= boundary ? '0 : bit_cnt_q + CntW'(1);
            word_valid_q <= 1'b0;
            lock_lost_q  <= 1'b0;

            case (state_q)
                StSearch: begin
                    if (match) begin
                        // The comma just seen ends a symbol: restart the phase.
                        bit_cnt_q   <= '0;
                        align_cnt_q <= 3'd1;
                        if (COMMA_COUNT == 1) begin
                            state_q        <= StActive;
                            active_q       <= 1'b1;
                            misalign_cnt_q <= '0;
                        end else begin
                            state_q <= StAlign;
                        end
                    end
                end

                StAlign: begin
                    if (boundary) begin
                        if (match) begin
                            align_cnt_q <= align_inc;
                            if (align_inc == 3'(COMMA_COUNT)) begin
                                state_q        <= StActive;
                                active_q       <= 1'b1;
                                misalign_cnt_q <= '0;
                            end
                        end else begin
                            state_q     <= StSearch;
                            align_cnt_q <= '0;
                        end
                    end else if (match) begin
                        // Comma on a new phase: adopt it and start counting again.
                        bit_cnt_q   <= '0;
                        align_cnt_q <= 3'd1;
                    end
                end

                StActive: begin
                    if (boundary) begin
                        data_q       <= cand;
                        word_valid_q <= 1'b1;
                        comma_det_q  <= match;
                        if (match) begin
                            misalign_cnt_q <= '0;
                        end
                    end else if (match) begin
                        // Phase is deliberately not tracked here; only a run of
                        // off-phase commas may break the lock.
                        if (misalign_inc == 3'(LOSS_LIMIT)) begin
                            state_q        <= StSearch;
                            active_q       <= 1'b0;
                            lock_lost_q    <= 1'b1;
                            misalign_cnt_q <= '0;
                        end else begin
                            misalign_cnt_q <= misalign_inc;
                        end
                    end
                end

                default: begin
                    state_q  <= StSearch;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign word_valid = word_valid_q;
    assign comma_det  = comma_det_q;
    assign active     = active_q;
    assign lock_lost  = lock_lost_q;
    assign state      = state_q;

endmodule

// File: tb/tb_serial_lane_sync.sv
// Directed bench for serial_lane_sync: lock acquisition, word output, ALIGN
// abort, realignment, lock loss and mid-word reset.
module tb_serial_lane_sync;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [9:0] data_out;
    logic       word_valid;
    logic       comma_det;
    logic       active;
    logic       lock_lost;
    logic [1:0] state;

    int n_vec;
    int n_err;
    int wv_cnt;
    int ll_cnt;
    int both_cnt;

    serial_lane_sync dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .word_valid (word_valid),
        .comma_det  (comma_det),
        .active     (active),
        .lock_lost  (lock_lost),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift n bits of v in, MSB first; sample outputs 1 time unit after each edge.
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            serial_in = v[i];
            @(posedge clk);
            #1;
            if (word_valid) wv_cnt++;
            if (lock_lost) ll_cnt++;
            if (word_valid && lock_lost) both_cnt++;
        end
    endtask

    task automatic pulse_reset();
        reset     = 1'b1;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        wv_cnt    = 0;
        ll_cnt    = 0;
        both_cnt  = 0;
        reset     = 1'b1;
        serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_comma_det", 32'(comma_det), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        reset = 1'b0;

        // Lock on three aligned commas, then three data words
        send_bits(32'h17C, 10);
        chk("lock_align_t0p1", 32'(state), 32'd1);
        chk("lock_inactive_1", 32'(active), 32'd0);
        send_bits(32'h17C, 10);
        chk("lock_align_2", 32'(state), 32'd1);
        send_bits(32'h17C, 10);
        chk("lock_active_state", 32'(state), 32'd2);
        chk("lock_active", 32'(active), 32'd1);
        chk("lock_no_word_yet", 32'(wv_cnt), 32'd0);
        send_bits(32'h0FF, 10);
        chk("w0_valid", 32'(word_valid), 32'd1);
        chk("w0_data", 32'(data_out), 32'h0FF);
        chk("w0_comma", 32'(comma_det), 32'd0);
        chk("w0_single", 32'(wv_cnt), 32'd1);
        send_bits(32'h3DD, 10);
        chk("w1_data", 32'(data_out), 32'h3DD);
        chk("w1_count", 32'(wv_cnt), 32'd2);
        send_bits(32'h0EE, 10);
        chk("w2_data", 32'(data_out), 32'h0EE);
        chk("w2_comma", 32'(comma_det), 32'd0);
        send_bits(32'h17C, 10);
        chk("wc_data", 32'(data_out), 32'h17C);
        chk("wc_comma", 32'(comma_det), 32'd1);
        send_bits(32'h0, 1);
        chk("wc_strobe_drop", 32'(word_valid), 32'd0);
        send_bits(32'h0, 9);

        // Off-phase 0x283 commas (each ends 3 bits before a boundary)
        send_bits(32'h005, 10);
        chk("seg_w_a", 32'(data_out), 32'h005);
        send_bits(32'h018, 10);
        chk("seg_w_b", 32'(data_out), 32'h018);
        send_bits(32'h01418, 20);
        send_bits(32'h01418, 20);
        chk("mis3_hold", 32'(active), 32'd1);
        send_bits(32'h17C, 10);
        chk("mis_reset_comma", 32'(comma_det), 32'd1);
        send_bits(32'h01418, 20);
        send_bits(32'h01418, 20);
        send_bits(32'h01418, 20);
        chk("mis3b_hold", 32'(active), 32'd1);
        chk("mis3b_no_loss", 32'(ll_cnt), 32'd0);
        send_bits(32'h00283, 17);
        chk("loss_pulse", 32'(lock_lost), 32'd1);
        chk("loss_active", 32'(active), 32'd0);
        chk("loss_state", 32'(state), 32'd0);
        chk("loss_no_word", 32'(word_valid), 32'd0);
        chk("loss_data_hold", 32'(data_out), 32'h005);
        send_bits(32'h0, 3);
        chk("loss_pulse_end", 32'(lock_lost), 32'd0);
        chk("loss_pulse_once", 32'(ll_cnt), 32'd1);
        send_bits(32'h0, 10);
        chk("search_data_hold", 32'(data_out), 32'h005);

        // Non-comma at an ALIGN boundary aborts to SEARCH
        send_bits(32'h17C, 10);
        send_bits(32'h17C, 10);
        send_bits(32'h0BB, 10);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_active", 32'(active), 32'd0);
        send_bits(32'h17C, 10);
        chk("restart_align", 32'(state), 32'd1);
        send_bits(32'h17C, 10);
        chk("restart_not_locked", 32'(active), 32'd0);
        send_bits(32'h17C, 10);
        chk("restart_locked", 32'(active), 32'd1);

        // Realign inside ALIGN: comma ending one bit before the old boundary
        pulse_reset();
        send_bits(32'h17C, 10);
        send_bits(32'h17C, 10);
        send_bits(32'h17C, 9);     // last 9 bits plus the prior 0 form a comma
        send_bits(32'h0, 1);       // old boundary: no abort if realigned
        chk("realign_hold", 32'(state), 32'd1);
        send_bits(32'h17C, 9);     // completes 0x17C on the new phase
        chk("realign_cnt2", 32'(state), 32'd1);
        chk("realign_not_locked", 32'(active), 32'd0);
        send_bits(32'h17C, 10);
        chk("realign_locked", 32'(state), 32'd2);
        send_bits(32'h155, 10);
        chk("realign_word_valid", 32'(word_valid), 32'd1);
        chk("realign_word_data", 32'(data_out), 32'h155);

        // Reset mid-word while ACTIVE
        send_bits(32'hA, 4);
        pulse_reset();
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_active", 32'(active), 32'd0);
        chk("mrst_data", 32'(data_out), 32'd0);
        chk("mrst_word_valid", 32'(word_valid), 32'd0);
        chk("mrst_comma", 32'(comma_det), 32'd0);
        chk("mrst_lock_lost", 32'(lock_lost), 32'd0);
        send_bits(32'h17C, 10);
        chk("relock_align", 32'(state), 32'd1);
        send_bits(32'h17C, 10);
        chk("relock_not_yet", 32'(active), 32'd0);
        send_bits(32'h17C, 10);
        chk("relock_done", 32'(active), 32'd1);

        chk("strobes_exclusive", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
